// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache arbiter: FSM state encoding,
// transaction owner encoding and the starvation counter width.
package cache_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_t;

endpackage

// File: rtl/cache_arb_stats.sv
// Hit/miss counters for responses forwarded by the cache arbiter.
// Both counters wrap modulo 2^32 and clear on reset.
module cache_arb_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resp_fire,
    input  logic        hit,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    // Count each completed transaction as either a hit or a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (resp_fire) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache port between the instruction-fetch requester (I, read
// only) and the data requester (D, read/write). D has fixed priority, with a
// starvation counter that hands I the port after MAX_CONSEC_D contested D
// grants. Optional hit/miss statistics are built when CACHE_ARB_STATS_EN is
// defined; otherwise the stat outputs are tied to 0.
//
// state    | meaning
// ARB_IDLE | arbitrating; winner drives the cache combinationally
// ARB_WAIT | request issued; cache inputs held, response routed to owner
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int MAX_CONSEC_D = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_req_valid,
    input  logic [31:0] d_addr,
    input  logic        d_mem_read,
    input  logic        d_mem_write,
    input  logic [31:0] d_din,
    output logic        d_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_dout,
    output logic        d_hit,
    input  logic        i_req_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_resp_valid,
    output logic [31:0] i_dout,
    output logic        i_hit,
    output logic        c_is_input_valid,
    output logic [31:0] c_addr,
    output logic        c_mem_read,
    output logic        c_mem_write,
    output logic [31:0] c_din,
    input  logic        c_is_ready,
    input  logic        c_is_output_valid,
    input  logic [31:0] c_dout,
    input  logic        c_is_hit,
    output logic [31:0] stat_hit_cnt,
    output logic [31:0] stat_miss_cnt
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_CONSEC_D);

    arb_state_t          state_q, state_d;
    owner_t              owner_q;
    logic [31:0]         addr_q, din_q;
    logic                read_q, write_q;
    logic [STARVE_W-1:0] starve_q;
    logic                grant_d, grant_i, handshake;

    // Arbitration, cache-port muxing and response routing. Every output is
    // forced to 0 while reset is asserted, including the combinational paths.
    always_comb begin
        state_d          = state_q;
        grant_d          = 1'b0;
        grant_i          = 1'b0;
        handshake        = 1'b0;
        d_ready          = 1'b0;
        i_ready          = 1'b0;
        d_resp_valid     = 1'b0;
        d_dout           = '0;
        d_hit            = 1'b0;
        i_resp_valid     = 1'b0;
        i_dout           = '0;
        i_hit            = 1'b0;
        c_is_input_valid = 1'b0;
        c_addr           = '0;
        c_mem_read       = 1'b0;
        c_mem_write      = 1'b0;
        c_din            = '0;
        if (!reset) begin
            state_d = ARB_IDLE;
        end else if (state_q == ARB_IDLE) begin
            if (i_req_valid && (!d_req_valid || starve_q == STARVE_MAX)) begin
                grant_i = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end
            if (grant_i) begin
                c_is_input_valid = 1'b1;
                c_addr           = i_addr;
                c_mem_read       = 1'b1;
            end else if (grant_d) begin
                // write wins over read; neither set is treated as a read
                c_is_input_valid = 1'b1;
                c_addr           = d_addr;
                c_mem_write      = d_mem_write;
                c_mem_read       = !d_mem_write;
                c_din            = d_din;
            end
            if (c_is_input_valid && c_is_ready) begin
                handshake = 1'b1;
                d_ready   = grant_d;
                i_ready   = grant_i;
                state_d   = ARB_WAIT;
            end
        end else begin
            c_addr      = addr_q;
            c_mem_read  = read_q;
            c_mem_write = write_q;
            c_din       = din_q;
            if (c_is_output_valid) begin
                if (owner_q == OWN_D) begin
                    d_resp_valid = 1'b1;
                    d_dout       = c_dout;
                    d_hit        = c_is_hit;
                end else begin
                    i_resp_valid = 1'b1;
                    i_dout       = c_dout;
                    i_hit        = c_is_hit;
                end
                state_d = ARB_IDLE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the normalised winning command so the cache sees it stable in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_D;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            din_q   <= '0;
        end else if (handshake) begin
            owner_q <= grant_i ? OWN_I : OWN_D;
            addr_q  <= c_addr;
            read_q  <= c_mem_read;
            write_q <= c_mem_write;
            din_q   <= c_din;
        end
    end

    // Count contested D grants; an I grant resets the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else if (handshake) begin
            if (grant_i) begin
                starve_q <= '0;
            end else if (i_req_valid && starve_q != STARVE_MAX) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

`ifdef CACHE_ARB_STATS_EN
    logic resp_fire;
    assign resp_fire = reset && (state_q == ARB_WAIT) && c_is_output_valid;

    cache_arb_stats u_stats (
        .clk      (clk),
        .rst_n    (reset),
        .resp_fire(resp_fire),
        .hit      (c_is_hit),
        .hit_cnt  (stat_hit_cnt),
        .miss_cnt (stat_miss_cnt)
    );
`else
    assign stat_hit_cnt  = '0;
    assign stat_miss_cnt = '0;
`endif

endmodule
